// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Single-port data memory responder for a load/store datapath. One request
//   is accepted at a time. The response becomes valid LATENCY cycles after the
//   acceptance edge and is held until the datapath takes it.
//
//   Parameters
//     DEPTH   : number of 32-bit words (power of two, 16..1024)
//     LATENCY : cycles from acceptance edge to resp_valid (1..15)
//
//   Ports
//     clock, reset             : clock, synchronous active-high reset
//     req_valid/req_write      : request strobe, 1 = store / 0 = load
//     req_addr/req_wdata       : byte address and store data
//     req_ready                : high only in IDLE
//     resp_valid/resp_ready    : response handshake
//     resp_rdata/resp_error    : load data (0 for stores/errors), error flag
//     mmio_out                 : MMIO register at 0x0000FF00
//                                (exists only when DMEM_MMIO_EN is defined)
//
//   Build option: define DMEM_MMIO_EN to add the MMIO register and mmio_out.

module data_mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
`ifdef DMEM_MMIO_EN
    ,
    output logic [31:0] mmio_out
`endif
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] MEM_BYTES = 32'(DEPTH * 4);
    localparam logic [3:0]  CNT_LOAD  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;
    logic        accept;
    logic        commit;
    logic        misaligned, hit_mem, hit_mmio;
    logic [AW-1:0] idx;
    logic [31:0] rd_word;
    logic        mem_we;

    logic [31:0] mem_q [DEPTH];

`ifdef DMEM_MMIO_EN
    localparam logic [31:0] MMIO_ADDR = 32'h0000_FF00;
    logic [31:0] mmio_q;
`endif

    assign idx        = addr_q[AW+1:2];
    assign misaligned = (addr_q[1:0] != 2'b00);
    assign hit_mem    = !misaligned && (addr_q < MEM_BYTES);
`ifdef DMEM_MMIO_EN
    assign hit_mmio   = (addr_q == MMIO_ADDR);
`else
    assign hit_mmio   = 1'b0;
`endif

    // Read data is taken from the array before the commit edge, so a load
    // always sees the word as it stood before any write on that edge.
    always_comb begin
        rd_word = 32'h0;
        if (!write_q) begin
            if (hit_mem) begin
                rd_word = mem_q[idx];
            end
`ifdef DMEM_MMIO_EN
            else if (hit_mmio) begin
                rd_word = mmio_q;
            end
`endif
        end
    end

    // LATENCY = 1 loads a zero count, so the single WAIT cycle commits on
    // the next edge and every LATENCY lands resp_valid on edge N+LATENCY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        error_d = error_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    rdata_d = rd_word;
                    error_d = !(hit_mem || hit_mmio);
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    // Request capture; only the acceptance cycle matters.
    always_ff @(posedge clock) begin
        if (accept && !reset) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Array is deliberately not reset; reset on the commit edge blocks the write.
    assign mem_we = commit && write_q && hit_mem && !reset;

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[idx] <= wdata_q;
        end
    end

`ifdef DMEM_MMIO_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            mmio_q <= 32'h0;
        end else if (commit && write_q && hit_mmio) begin
            mmio_q <= wdata_q;
        end
    end

    assign mmio_out = mmio_q;
`endif

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_error = error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: DEPTH=64 with LATENCY 2 (main),
// 1 and 15 (latency sweeps). Define DMEM_MMIO_EN to cover the MMIO register.

module tb_data_mem_responder;

    logic        clock;
    logic        reset;
    logic        rv   [3];
    logic        rw   [3];
    logic [31:0] ra   [3];
    logic [31:0] rwd  [3];
    logic        rq_rdy [3];
    logic        rs_vld [3];
    logic        rs_rdy [3];
    logic [31:0] rs_dat [3];
    logic        rs_err [3];
`ifdef DMEM_MMIO_EN
    logic [31:0] mmio [3];
`endif

    int n_chk  = 0;
    int n_pass = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    data_mem_responder #(.DEPTH(64), .LATENCY(2)) u_dut_l2 (
`ifdef DMEM_MMIO_EN
        .mmio_out   (mmio[0]),
`endif
        .clock      (clock),
        .reset      (reset),
        .req_valid  (rv[0]),
        .req_write  (rw[0]),
        .req_addr   (ra[0]),
        .req_wdata  (rwd[0]),
        .req_ready  (rq_rdy[0]),
        .resp_valid (rs_vld[0]),
        .resp_ready (rs_rdy[0]),
        .resp_rdata (rs_dat[0]),
        .resp_error (rs_err[0])
    );

    data_mem_responder #(.DEPTH(64), .LATENCY(1)) u_dut_l1 (
`ifdef DMEM_MMIO_EN
        .mmio_out   (mmio[1]),
`endif
        .clock      (clock),
        .reset      (reset),
        .req_valid  (rv[1]),
        .req_write  (rw[1]),
        .req_addr   (ra[1]),
        .req_wdata  (rwd[1]),
        .req_ready  (rq_rdy[1]),
        .resp_valid (rs_vld[1]),
        .resp_ready (rs_rdy[1]),
        .resp_rdata (rs_dat[1]),
        .resp_error (rs_err[1])
    );

    data_mem_responder #(.DEPTH(64), .LATENCY(15)) u_dut_l15 (
`ifdef DMEM_MMIO_EN
        .mmio_out   (mmio[2]),
`endif
        .clock      (clock),
        .reset      (reset),
        .req_valid  (rv[2]),
        .req_write  (rw[2]),
        .req_addr   (ra[2]),
        .req_wdata  (rwd[2]),
        .req_ready  (rq_rdy[2]),
        .resp_valid (rs_vld[2]),
        .resp_ready (rs_rdy[2]),
        .resp_rdata (rs_dat[2]),
        .resp_error (rs_err[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // One full transaction on instance i. lat counts edges from acceptance
    // to the first edge showing resp_valid. Address/data are scrambled right
    // after acceptance; the DUT must not see that.
    task automatic req(input int i, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, output int lat,
                       output logic [31:0] rdata, output logic err);
        int k;
        @(negedge clock);
        rv[i]  = 1'b1;
        rw[i]  = wr;
        ra[i]  = addr;
        rwd[i] = wdata;
        @(posedge clock);
        #1;
        rv[i]  = 1'b0;
        ra[i]  = ~addr;
        rwd[i] = 32'h0BAD_0BAD;
        k = 0;
        while (!rs_vld[i] && k < 40) begin
            @(posedge clock);
            #1;
            k++;
        end
        lat   = k;
        rdata = rs_dat[i];
        err   = rs_err[i];
        rs_rdy[i] = 1'b1;
        @(posedge clock);
        #1;
        rs_rdy[i] = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        int          k;
        int          seen;

        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = 32'h0; rwd[i] = 32'h0; rs_rdy[i] = 1'b0;
        end
        do_reset();

        // Reset state
        chk("rst_req_ready",  {31'h0, rq_rdy[0]}, 32'h1);
        chk("rst_resp_valid", {31'h0, rs_vld[0]}, 32'h0);
        chk("rst_rdata",      rs_dat[0],          32'h0);
        chk("rst_error",      {31'h0, rs_err[0]}, 32'h0);

        // Store then load, latency 2
        req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, lat, rd, er);
        chk("st10_lat",   lat, 2);
        chk("st10_err",   {31'h0, er}, 32'h0);
        chk("st10_rdata", rd, 32'h0);
        chk("idle_req_ready", {31'h0, rq_rdy[0]}, 32'h1);
        req(0, 1'b0, 32'h10, 32'h0, lat, rd, er);
        chk("ld10_lat",   lat, 2);
        chk("ld10_rdata", rd, 32'hDEAD_BEEF);
        chk("ld10_err",   {31'h0, er}, 32'h0);

        // Errors: misaligned and out of range
        req(0, 1'b1, 32'h0, 32'h1111_1111, lat, rd, er);
        req(0, 1'b1, 32'hFC, 32'h7777_0FC0, lat, rd, er);
        chk("stFC_err", {31'h0, er}, 32'h0);
        req(0, 1'b0, 32'h12, 32'h0, lat, rd, er);
        chk("ld12_rdata", rd, 32'h0);
        chk("ld12_err",   {31'h0, er}, 32'h1);
        req(0, 1'b0, 32'h100, 32'h0, lat, rd, er);
        chk("ld100_rdata", rd, 32'h0);
        chk("ld100_err",   {31'h0, er}, 32'h1);
        req(0, 1'b1, 32'h100, 32'h5555_5555, lat, rd, er);
        chk("st100_err", {31'h0, er}, 32'h1);
        req(0, 1'b1, 32'h12, 32'h6666_6666, lat, rd, er);
        chk("st12_err", {31'h0, er}, 32'h1);
        req(0, 1'b0, 32'h0, 32'h0, lat, rd, er);
        chk("ld0_after_bad_store", rd, 32'h1111_1111);
        req(0, 1'b0, 32'h10, 32'h0, lat, rd, er);
        chk("ld10_after_bad_store", rd, 32'hDEAD_BEEF);
        req(0, 1'b0, 32'hFC, 32'h0, lat, rd, er);
        chk("ldFC_last_word", rd, 32'h7777_0FC0);

        // MMIO address
`ifdef DMEM_MMIO_EN
        req(0, 1'b1, 32'hFF00, 32'hA5, lat, rd, er);
        chk("mmio_st_err", {31'h0, er}, 32'h0);
        chk("mmio_out",    mmio[0], 32'hA5);
        req(0, 1'b0, 32'hFF00, 32'h0, lat, rd, er);
        chk("mmio_ld_lat",   lat, 2);
        chk("mmio_ld_rdata", rd, 32'hA5);
        chk("mmio_ld_err",   {31'h0, er}, 32'h0);
        do_reset();
        chk("mmio_rst", mmio[0], 32'h0);
`else
        req(0, 1'b0, 32'hFF00, 32'h0, lat, rd, er);
        chk("ffoo_ld_err",   {31'h0, er}, 32'h1);
        chk("ffoo_ld_rdata", rd, 32'h0);
`endif

        // Backpressure: hold resp_ready low for 5 cycles
        @(negedge clock);
        rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 32'h10;
        @(posedge clock);
        #1;
        rv[0] = 1'b0; ra[0] = 32'h0;
        k = 0;
        while (!rs_vld[0] && k < 40) begin
            @(posedge clock);
            #1;
            k++;
        end
        chk("hold_lat", k, 2);
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            #1;
            chk("hold_valid",     {31'h0, rs_vld[0]}, 32'h1);
            chk("hold_rdata",     rs_dat[0], 32'hDEAD_BEEF);
            chk("hold_err",       {31'h0, rs_err[0]}, 32'h0);
            chk("hold_req_ready", {31'h0, rq_rdy[0]}, 32'h0);
        end
        @(negedge clock);
        rs_rdy[0] = 1'b1;
        @(posedge clock);
        #1;
        rs_rdy[0] = 1'b0;
        chk("hs_req_ready",  {31'h0, rq_rdy[0]}, 32'h1);
        chk("hs_resp_valid", {31'h0, rs_vld[0]}, 32'h0);

        // resp_ready while idle is ignored
        @(negedge clock);
        rs_rdy[0] = 1'b1;
        @(posedge clock);
        #1;
        rs_rdy[0] = 1'b0;
        chk("idle_rr_req_ready", {31'h0, rq_rdy[0]}, 32'h1);
        chk("idle_rr_valid",     {31'h0, rs_vld[0]}, 32'h0);

        // Reset one cycle after accepting a store aborts it
        req(0, 1'b1, 32'h20, 32'hCAFE_F00D, lat, rd, er);
        @(negedge clock);
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h20; rwd[0] = 32'h1234_5678;
        @(posedge clock);
        #1;
        rv[0] = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("abort_req_ready", {31'h0, rq_rdy[0]}, 32'h1);
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clock);
            #1;
            if (rs_vld[0]) seen++;
        end
        chk("abort_no_resp", seen, 0);
        req(0, 1'b0, 32'h20, 32'h0, lat, rd, er);
        chk("abort_ld20", rd, 32'hCAFE_F00D);

        // Latency sweeps
        req(1, 1'b1, 32'h8, 32'h0000_0101, lat, rd, er);
        chk("l1_st_lat", lat, 1);
        req(1, 1'b0, 32'h8, 32'h0, lat, rd, er);
        chk("l1_ld_lat",   lat, 1);
        chk("l1_ld_rdata", rd, 32'h0000_0101);
        req(2, 1'b1, 32'h3C, 32'h0F0F_1515, lat, rd, er);
        chk("l15_st_lat", lat, 15);
        req(2, 1'b0, 32'h3C, 32'h0, lat, rd, er);
        chk("l15_ld_lat",   lat, 15);
        chk("l15_ld_rdata", rd, 32'h0F0F_1515);
        req(2, 1'b0, 32'h3E, 32'h0, lat, rd, er);
        chk("l15_mis_err", {31'h0, er}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
